// File: rtl/pipe_pkg.sv
// Shared constants for the decode/execute pipeline slice.
// Widths, FSM encoding and the hard-wired zero register index.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;

  localparam int CNT_W = 3;

  localparam int REG_ZERO = 0;

  typedef logic [0:0] state_t;

  localparam state_t RUN   = 1'b0;
  localparam state_t STALL = 1'b1;

endpackage

// File: rtl/id_ex_stage_operand_select.sv
// One operand path into EX: optional write-back bypass, then x0 forcing.
// Bypass is compiled in only when ID_WB_BYPASS_EN is defined.
module operand_select
  import pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] rf_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] op
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic          hit;
  logic [DW-1:0] src;

`ifdef ID_WB_BYPASS_EN
  assign hit = wb_we & (wb_rd != ZERO) & (wb_rd == rs);
`else
  logic unused_wb;
  assign hit       = 1'b0;
  assign unused_wb = ^{wb_we, wb_rd};
`endif

  // Pick the source, then x0 overrides whatever was selected.
  always_comb begin
    src = hit ? wb_data : rf_data;
    op  = src;
    if (rs == ZERO) begin
      op = '0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM and branch flush.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into EX.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW           = DATA_W,
  parameter int AW           = ADDR_W,
  parameter int CW           = CTRL_W,
  parameter int STALL_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic [AW-1:0] id_rs3,
  input  logic [AW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic [CW-1:0] id_ctrl,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic [DW-1:0] rf_data3,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_op1,
  output logic [DW-1:0] ex_op2,
  output logic [DW-1:0] ex_op3,
  output logic [AW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic [CW-1:0] ex_ctrl
);

  localparam logic [AW-1:0]    ZERO     = AW'(REG_ZERO);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STALL_CYCLES - 1);
  localparam bit               MULTI    = (STALL_CYCLES > 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          ex_valid_q, ex_valid_d;
  logic          ex_reg_write_q, ex_reg_write_d;
  logic          ex_mem_read_q, ex_mem_read_d;
  logic [DW-1:0] ex_op1_q, ex_op1_d;
  logic [DW-1:0] ex_op2_q, ex_op2_d;
  logic [DW-1:0] ex_op3_q, ex_op3_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;

  logic [DW-1:0] op1, op2, op3;
  logic          hazard;
  logic          bubble;
  logic          stall_c;

  operand_select #(.DW(DW), .AW(AW)) u_op1 (
    .rs      (id_rs1),
    .rf_data (rf_data1),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op1)
  );

  operand_select #(.DW(DW), .AW(AW)) u_op2 (
    .rs      (id_rs2),
    .rf_data (rf_data2),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op2)
  );

  operand_select #(.DW(DW), .AW(AW)) u_op3 (
    .rs      (id_rs3),
    .rf_data (rf_data3),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .op      (op3)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = id_valid & ex_valid_q & ex_mem_read_q
           & (ex_rd_q != ZERO)
           & ((ex_rd_q == id_rs1)
            | (ex_rd_q == id_rs2)
            | (ex_rd_q == id_rs3));
  end

  // Stall FSM: flush beats hazard; STALL counts down the extra bubbles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    bubble  = 1'b0;
    if (flush) begin
      bubble  = 1'b1;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            stall_c = 1'b1;
            bubble  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = MULTI ? STALL : RUN;
          end
        end
        STALL: begin
          stall_c = 1'b1;
          bubble  = 1'b1;
          cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // Upstream freeze is suppressed while reset is held.
  always_comb begin
    stall = stall_c & ~rst;
  end

  // Next EX contents: a bubble clears the qualifiers and holds the data.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_op1_d       = ex_op1_q;
    ex_op2_d       = ex_op2_q;
    ex_op3_d       = ex_op3_q;
    ex_rd_d        = ex_rd_q;
    ex_ctrl_d      = ex_ctrl_q;
    if (!bubble) begin
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_valid & id_reg_write;
      ex_mem_read_d  = id_valid & id_mem_read;
      ex_op1_d       = op1;
      ex_op2_d       = op2;
      ex_op3_d       = op3;
      ex_rd_d        = id_rd;
      ex_ctrl_d      = id_ctrl;
    end
  end

  // State and EX register; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      ex_op3_q       <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_op1_q       <= ex_op1_d;
      ex_op2_q       <= ex_op2_d;
      ex_op3_q       <= ex_op3_d;
      ex_rd_q        <= ex_rd_d;
      ex_ctrl_q      <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign ex_op3       = ex_op3_q;
  assign ex_rd        = ex_rd_q;
  assign ex_ctrl      = ex_ctrl_q;

endmodule
